// File: rtl/versat_dma_rd.sv
// Read DMA for the Versat DDR port: splits a beat-count read command into
// AXI4 INCR bursts that stay inside 4 KB pages and streams beats out via a FIFO.
module versat_dma_rd #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned FIFO_AW   = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              done,
    output logic              err,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,

    output logic              m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int unsigned BSH   = $clog2(DATA_W / 8);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned CW_A  = (LEN_W > CNT_W) ? LEN_W : CNT_W;
    localparam int unsigned CW    = ((CW_A > 13) ? CW_A : 13) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((DATA_W / 8) - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    rem;

    logic [DATA_W:0]     mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    free;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                last_tag;

    logic [12:0]         room;
    logic [CW-1:0]       blen_w;
    logic [8:0]          blen;

    assign m_axi_arid    = 1'b0;
    assign m_axi_arsize  = 3'(BSH);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign free       = CNT_W'(DEPTH) - count;

    assign cmd_ready    = (state == IDLE);
    assign m_axi_rready = (state == DATA) && !fifo_full;
    assign out_valid    = !fifo_empty;
    assign {out_last, out_data} = mem[rd_ptr];

    assign push     = m_axi_rvalid && m_axi_rready;
    assign pop      = out_valid && out_ready;
    assign last_tag = m_axi_rlast && (rem == '0);

    // Beats left before the next 4 KB page boundary.
    assign room = 13'((13'h1000 - {1'b0, addr[11:0]}) >> BSH);

    // Burst length: min(remaining, MAX_BURST, beats to page end).
    always_comb begin
        blen_w = CW'(rem);
        if (blen_w > CW'(MAX_BURST)) blen_w = CW'(MAX_BURST);
        if (blen_w > CW'(room))      blen_w = CW'(room);
    end
    assign blen = 9'(blen_w);

    // Command / burst sequencing with registered AR channel and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            rem           <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
        end else begin
            done <= 1'b0;
            if (push && (m_axi_rresp != 2'b00)) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr  <= cmd_addr & ALIGN_MASK;
                        rem   <= cmd_len;
                        err   <= 1'b0;
                        state <= (cmd_len == '0) ? DRAIN : ADDR;
                    end
                end
                ADDR: begin
                    // No pushes happen here, so free space only grows once checked.
                    if (!m_axi_arvalid) begin
                        if (CW'(free) >= CW'(blen)) begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= addr;
                            m_axi_arlen   <= 8'(blen - 9'd1);
                        end
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        addr          <= addr + (ADDR_W'(blen) << BSH);
                        rem           <= rem - LEN_W'(blen);
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (push && m_axi_rlast) state <= (rem != '0) ? ADDR : DRAIN;
                end
                DRAIN: begin
                    if ((pop && out_last) || fifo_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {last_tag, m_axi_rdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_versat_dma_rd.sv
// Directed bench for versat_dma_rd: table of read commands with expected bursts,
// an AXI read-slave model, an in-order beat checker and a mid-transfer reset.
module tb_versat_dma_rd;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_len;
    logic         done, err;
    logic         out_valid, out_ready, out_last;
    logic [255:0] out_data;
    logic         arid, arlock, arvalid, arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, rresp;
    logic [3:0]   arcache, arqos;
    logic [255:0] rdata;
    logic         rlast, rvalid, rready;

    always #5 clk = ~clk;

    versat_dma_rd dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          stall;
        bit          throttle;
        int          err_beat;
        bit          exp_err;
        int          nb;
        logic [31:0] ba [4];
        logic [7:0]  bl [4];
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } burst_t;

    int errors = 0;
    int checks = 0;

    vec_t        vecs [7];
    burst_t      bq [$];
    logic [31:0] rec_a [$];
    logic [7:0]  rec_l [$];
    int          beat_k, rbeats, err_beat, nout, done_cnt, arv_cnt;
    logic [31:0] salt, base;
    logic [15:0] exp_len;
    bit          slave_en, cons_en, hold, throttle, r_fired;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI read slave: random arready, one beat stream per accepted burst.
    always @(negedge clk) begin
        if (!slave_en) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
            r_fired = 1'b0; beat_k = 0; bq.delete();
        end else begin
            if (!(rvalid && !r_fired)) begin
                if (bq.size() != 0 && $urandom_range(0, 3) != 0) begin
                    rvalid = 1'b1;
                    rdata  = {{7{bq[0].a + 32'(beat_k * 32)}}, salt};
                    rlast  = (beat_k == int'(bq[0].l));
                    rresp  = (rbeats + 1 == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
            r_fired = rvalid && rready;
            if (r_fired) begin
                rbeats++;
                if (rlast) begin
                    void'(bq.pop_front());
                    beat_k = 0;
                end else begin
                    beat_k++;
                end
            end
            arready = ($urandom_range(0, 3) != 0);
            if (arvalid && arready) begin
                bq.push_back('{araddr, arlen});
                rec_a.push_back(araddr);
                rec_l.push_back(arlen);
                check("no_4k_cross",
                      256'((int'(araddr[11:0]) + (int'(arlen) + 1) * 32) > 4096), 256'(0));
            end
        end
    end

    // Consumer: checks every popped beat against the command's address sequence.
    always @(negedge clk) begin
        if (!cons_en) begin
            out_ready = 1'b0;
        end else begin
            out_ready = !hold && (throttle ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (out_valid && out_ready) begin
                check($sformatf("beat_data[%0d]", nout), out_data,
                      {{7{base + 32'(nout) * 32'd32}}, salt});
                check($sformatf("beat_last[%0d]", nout), 256'(out_last),
                      256'(nout == int'(exp_len) - 1));
                nout++;
            end
        end
    end

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (arvalid) arv_cnt++;
    end

    task automatic run_cmd(input vec_t v, input int idx);
        int lat;
        salt = 32'(idx + 1); base = v.addr & ~32'h1F; exp_len = v.len;
        throttle = v.throttle; err_beat = v.err_beat; hold = (v.stall > 0);
        nout = 0; rbeats = 0; done_cnt = 0; arv_cnt = 0;
        rec_a.delete(); rec_l.delete();
        slave_en = 1'b1; cons_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len;
        check($sformatf("v%0d_cmd_ready_idle", idx), 256'(cmd_ready), 256'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        check($sformatf("v%0d_err_cleared", idx), 256'(err), 256'(0));
        lat = 1;
        if (v.stall > 0) begin
            repeat (v.stall) @(negedge clk);
            lat += v.stall;
            check($sformatf("v%0d_stall_fill", idx), 256'(rbeats), 256'(32));
            check($sformatf("v%0d_stall_rready", idx), 256'(rready), 256'(0));
            hold = 1'b0;
        end
        while (!done && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_done_seen", idx), 256'(done), 256'(1));
        check($sformatf("v%0d_err_at_done", idx), 256'(err), 256'(v.exp_err));
        check($sformatf("v%0d_cmd_ready_after", idx), 256'(cmd_ready), 256'(1));
        if (v.len == 16'd0) begin
            check($sformatf("v%0d_len0_latency", idx), 256'(lat), 256'(2));
            check($sformatf("v%0d_len0_no_arvalid", idx), 256'(arv_cnt), 256'(0));
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_pulses", idx), 256'(done_cnt), 256'(1));
        check($sformatf("v%0d_err_held", idx), 256'(err), 256'(v.exp_err));
        check($sformatf("v%0d_beats_out", idx), 256'(nout), 256'(v.len));
        check($sformatf("v%0d_num_bursts", idx), 256'(rec_a.size()), 256'(v.nb));
        for (int i = 0; i < v.nb && i < rec_a.size(); i++) begin
            check($sformatf("v%0d_araddr[%0d]", idx, i), 256'(rec_a[i]), 256'(v.ba[i]));
            check($sformatf("v%0d_arlen[%0d]", idx, i), 256'(rec_l[i]), 256'(v.bl[i]));
        end
        slave_en = 1'b0; cons_en = 1'b0;
    endtask

    initial begin
        vec_t vpost;
        int   guard;
        vecs[0] = '{32'h0000_1000, 16'd40, 0,   1'b0, 0, 1'b0, 3,
                    '{32'h1000, 32'h1200, 32'h1400, 32'h0}, '{8'd15, 8'd15, 8'd7, 8'd0}};
        vecs[1] = '{32'h0000_0FC0, 16'd8,  0,   1'b1, 0, 1'b0, 2,
                    '{32'h0FC0, 32'h1000, 32'h0, 32'h0},    '{8'd1, 8'd5, 8'd0, 8'd0}};
        vecs[2] = '{32'h0000_2000, 16'd0,  0,   1'b0, 0, 1'b0, 0,
                    '{32'h0, 32'h0, 32'h0, 32'h0},          '{8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{32'h0000_2000, 16'd48, 100, 1'b0, 0, 1'b0, 3,
                    '{32'h2000, 32'h2200, 32'h2400, 32'h0}, '{8'd15, 8'd15, 8'd15, 8'd0}};
        vecs[4] = '{32'h0000_3000, 16'd4,  0,   1'b0, 3, 1'b1, 1,
                    '{32'h3000, 32'h0, 32'h0, 32'h0},       '{8'd3, 8'd0, 8'd0, 8'd0}};
        vecs[5] = '{32'h0000_301F, 16'd3,  0,   1'b1, 0, 1'b0, 1,
                    '{32'h3000, 32'h0, 32'h0, 32'h0},       '{8'd2, 8'd0, 8'd0, 8'd0}};
        vecs[6] = '{32'hFFFF_FFC0, 16'd4,  0,   1'b0, 0, 1'b0, 2,
                    '{32'hFFFF_FFC0, 32'h0, 32'h0, 32'h0},  '{8'd1, 8'd1, 8'd0, 8'd0}};
        vpost   = '{32'h0000_0040, 16'd4,  0,   1'b1, 0, 1'b0, 1,
                    '{32'h0040, 32'h0, 32'h0, 32'h0},       '{8'd3, 8'd0, 8'd0, 8'd0}};

        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        slave_en = 1'b0; cons_en = 1'b0; hold = 1'b1; throttle = 1'b0;
        salt = '0; base = '0; exp_len = '0; err_beat = 0; nout = 0; rbeats = 0;
        repeat (2) @(negedge clk);
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_arvalid", 256'(arvalid), 256'(0));
        check("rst_rready", 256'(rready), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_araddr", 256'(araddr), 256'(0));
        check("rst_arlen", 256'(arlen), 256'(0));
        check("const_arsize", 256'(arsize), 256'(5));
        check("const_arburst", 256'(arburst), 256'(1));
        check("const_arcache", 256'(arcache), 256'(3));
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 256'(cmd_ready), 256'(1));

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], i);

        // Reset while a 40-beat read is streaming.
        salt = 32'd99; base = 32'h5000; exp_len = 16'd40; throttle = 1'b1; hold = 1'b0;
        err_beat = 0; nout = 0; rbeats = 0;
        slave_en = 1'b1; cons_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h5000; cmd_len = 16'd40;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (rbeats < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reached_data", 256'(rbeats >= 5), 256'(1));
        #3 rst = 1'b0;
        #1;
        check("midrst_done", 256'(done), 256'(0));
        check("midrst_err", 256'(err), 256'(0));
        check("midrst_arvalid", 256'(arvalid), 256'(0));
        check("midrst_rready", 256'(rready), 256'(0));
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_araddr", 256'(araddr), 256'(0));
        check("midrst_arlen", 256'(arlen), 256'(0));
        slave_en = 1'b0; cons_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 256'(cmd_ready), 256'(1));
        run_cmd(vpost, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
